pixel_stream_feeder: RTL

//  Upstream stage of the I2LBS face-detection block. Takes the raw camera pixel stream and tags each pixel

---
 rtl/face_detect_pkg.sv | 37 +++
 rtl/feeder_fifo.sv | 61 ++++++
 rtl/pixel_stream_feeder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/face_detect_pkg.sv
// Shared types and constants for the face-detection front end.
// Luma helper is only referenced when PIXEL_GRAY_CONVERT_EN is defined.
package face_detect_pkg;

    localparam int DATA_WIDTH_12 = 12;
    localparam int DATA_WIDTH_16 = 16;

    localparam logic [7:0] LUMA_COEF_R = 8'd77;
    localparam logic [7:0] LUMA_COEF_G = 8'd150;
    localparam logic [7:0] LUMA_COEF_B = 8'd29;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2
    } feeder_state_t;

    typedef struct packed {
        logic [DATA_WIDTH_12-1:0] y;
        logic [DATA_WIDTH_12-1:0] x;
        logic [DATA_WIDTH_16-1:0] pixel;
    } feeder_entry_t;

    // RGB565 -> 8-bit luma; channels are left-justified into 8 bits before weighting.
    function automatic logic [DATA_WIDTH_16-1:0] rgb565_to_gray(input logic [DATA_WIDTH_16-1:0] p);
        logic [15:0] r16;
        logic [15:0] g16;
        logic [15:0] b16;
        logic [17:0] sum;
        r16 = {8'd0, p[15:11], 3'd0};
        g16 = {8'd0, p[10:5], 2'd0};
        b16 = {8'd0, p[4:0], 3'd0};
        sum = 18'(r16 * LUMA_COEF_R) + 18'(g16 * LUMA_COEF_G) + 18'(b16 * LUMA_COEF_B);
        return 16'(sum >> 8);
    endfunction

endpackage

// File: rtl/feeder_fifo.sv
// Synchronous FIFO of tagged pixels with full/empty/count flags.
module feeder_fifo
    import face_detect_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  feeder_entry_t            i_data,
    output feeder_entry_t            o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    feeder_entry_t   r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_stream_feeder.sv
// Tags camera pixels with frame coordinates, buffers them and hands them out as clean strobes.
// Optional RGB565-to-gray conversion on the write side: define PIXEL_GRAY_CONVERT_EN.
module pixel_stream_feeder
    import face_detect_pkg::*;
#(
    parameter int FRAME_ORIGINAL_CAMERA_WIDTH  = 10,
    parameter int FRAME_ORIGINAL_CAMERA_HEIGHT = 10,
    parameter int FIFO_DEPTH                   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH_16-1:0] i_pixel,
    input  logic                     i_valid,
    input  logic                     i_sof,
    input  logic                     pixel_request,
    output logic                     o_ready,
    output logic [DATA_WIDTH_16-1:0] o_pixel,
    output logic [DATA_WIDTH_12-1:0] o_ori_x,
    output logic [DATA_WIDTH_12-1:0] o_ori_y,
    output logic                     o_enable_recieve_pixel,
    output logic                     o_frame_done,
    output logic                     o_overflow
);

    localparam int CW = $clog2(FIFO_DEPTH);
    localparam logic [DATA_WIDTH_12-1:0] LAST_X = DATA_WIDTH_12'(FRAME_ORIGINAL_CAMERA_WIDTH - 1);
    localparam logic [DATA_WIDTH_12-1:0] LAST_Y = DATA_WIDTH_12'(FRAME_ORIGINAL_CAMERA_HEIGHT - 1);

    logic [DATA_WIDTH_12-1:0] r_x;
    logic [DATA_WIDTH_12-1:0] r_y;
    logic                     r_out_en;
    logic                     r_overflow;
    feeder_state_t            r_state;
    logic [DATA_WIDTH_16-1:0] r_pixel;
    logic [DATA_WIDTH_12-1:0] r_ori_x;
    logic [DATA_WIDTH_12-1:0] r_ori_y;
    logic                     r_strobe;
    logic                     r_frame_done;

    logic [DATA_WIDTH_12-1:0] w_tag_x;
    logic [DATA_WIDTH_12-1:0] w_tag_y;
    logic [DATA_WIDTH_12-1:0] w_next_x;
    logic [DATA_WIDTH_12-1:0] w_next_y;
    logic [DATA_WIDTH_16-1:0] w_pixel;
    feeder_entry_t            w_wr_entry;
    feeder_entry_t            w_rd_entry;
    logic                     w_full;
    logic                     w_empty;
    logic [CW:0]              w_count;
    logic                     w_push;
    logic                     w_pop;

`ifdef PIXEL_GRAY_CONVERT_EN
    assign w_pixel = rgb565_to_gray(i_pixel);
`else
    assign w_pixel = i_pixel;
`endif

    assign w_tag_x    = i_sof ? '0 : r_x;
    assign w_tag_y    = i_sof ? '0 : r_y;
    assign w_wr_entry = '{y: w_tag_y, x: w_tag_x, pixel: w_pixel};

    // Full is judged on the pre-pop occupancy, so a same-cycle pop never rescues a full push.
    assign w_push = i_valid && !w_full;
    assign w_pop  = (r_state == IDLE) && !w_empty && pixel_request;

    always_comb begin
        w_next_x = w_tag_x + DATA_WIDTH_12'(1);
        w_next_y = w_tag_y;
        if (w_tag_x == LAST_X) begin
            w_next_x = '0;
            w_next_y = (w_tag_y == LAST_Y) ? '0 : w_tag_y + DATA_WIDTH_12'(1);
        end
    end

    feeder_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_wr_entry),
        .o_data  (w_rd_entry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Dropped pixels still consume a coordinate so later pixels keep their true position.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_x        <= '0;
            r_y        <= '0;
            r_overflow <= 1'b0;
            r_out_en   <= 1'b0;
        end else begin
            r_out_en <= 1'b1;
            if (i_valid) begin
                r_x <= w_next_x;
                r_y <= w_next_y;
            end
            if (i_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_pixel      <= '0;
            r_ori_x      <= '0;
            r_ori_y      <= '0;
            r_strobe     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_frame_done <= 1'b0;
                    if (w_pop) begin
                        r_pixel  <= w_rd_entry.pixel;
                        r_ori_x  <= w_rd_entry.x;
                        r_ori_y  <= w_rd_entry.y;
                        r_strobe <= 1'b1;
                        r_state  <= STROBE;
                    end
                end
                STROBE: begin
                    r_strobe     <= 1'b0;
                    r_frame_done <= (r_ori_x == LAST_X) && (r_ori_y == LAST_Y);
                    r_state      <= GAP;
                end
                GAP: begin
                    r_frame_done <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_strobe     <= 1'b0;
                    r_frame_done <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign o_ready                = r_out_en && (w_count < (CW+1)'(FIFO_DEPTH));
    assign o_pixel                = r_pixel;
    assign o_ori_x                = r_ori_x;
    assign o_ori_y                = r_ori_y;
    assign o_enable_recieve_pixel = r_strobe;
    assign o_frame_done           = r_frame_done;
    assign o_overflow             = r_overflow;

endmodule
